// File: rtl/serdes_tx_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package : serdes_arb_pkg
// Shared state encoding and the round-robin search helper for serdes_tx_arbiter.
// Rev     : 1.0
// ----------------------------------------------------------------------------
package serdes_arb_pkg;

  localparam int unsigned c_rr_max_req = 32;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // First set index strictly after 'last', wrapping at num_req.
  function automatic int unsigned rr_next(input logic [c_rr_max_req-1:0] req,
                                          input int unsigned             last,
                                          input int unsigned             num_req);
    int unsigned idx;
    logic        found;
    rr_next = 0;
    found   = 1'b0;
    for (int unsigned off = 1; off <= c_rr_max_req; off++) begin
      if (off <= num_req) begin
        idx = (last + off) % num_req;
        if (!found && req[idx[4:0]]) begin
          rr_next = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/serdes_tx_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Interface : serdes_tx_arbiter_if
// Requester bus and serdes handshake seen by serdes_tx_arbiter.
// Rev       : 1.0
// ----------------------------------------------------------------------------
interface serdes_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) ();

  localparam int c_id_w = $clog2(NUM_REQ);

  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [DATA_WIDTH-1:0]         ser_data_o;
  logic                          ser_valid_o;
  logic                          ser_ready_i;
  logic [c_id_w-1:0]             grant_id_o;
  logic                          busy_o;

  modport master (
    input  req_data_i, req_valid_i, ser_ready_i,
    output req_ready_o, ser_data_o, ser_valid_o, grant_id_o, busy_o
  );

  modport slave (
    output req_data_i, req_valid_i, ser_ready_i,
    input  req_ready_o, ser_data_o, ser_valid_o, grant_id_o, busy_o
  );

endinterface
`default_nettype wire

// File: rtl/serdes_tx_arbiter_rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : rr_arbiter
// Combinational round-robin pick; SERDES_ARB_PRIO0_EN gives requester 0 priority.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module rr_arbiter
  import serdes_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [ID_W-1:0]    grant,
  output logic               any_req
);

  always_comb begin
    any_req = |req;
    grant   = ID_W'(rr_next(c_rr_max_req'(req), 32'(last), $unsigned(NUM_REQ)));
`ifdef SERDES_ARB_PRIO0_EN
    if (req[0]) begin
      grant = '0;
    end
`else
`endif
  end

endmodule
`default_nettype wire

// File: rtl/serdes_tx_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : serdes_tx_arbiter
// Round-robin burst scheduler feeding one serdes TX port (SERDES_ARB_PRIO0_EN option).
// Rev    : 1.0
// ----------------------------------------------------------------------------
module serdes_tx_arbiter
  import serdes_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  serdes_tx_arbiter_if.master bus
);

  localparam int c_id_w  = $clog2(NUM_REQ);
  localparam int c_cnt_w = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(MAX_BURST - 1);
  localparam logic [c_id_w-1:0]  c_last_rst  = c_id_w'(NUM_REQ - 1);

  arb_state_e          r_state, w_state_nxt;
  logic [c_id_w-1:0]   r_grant, w_grant_nxt;
  logic [c_id_w-1:0]   r_last, w_last_nxt;
  logic [c_cnt_w-1:0]  r_beat_cnt, w_beat_cnt_nxt;
  logic [c_id_w-1:0]   w_rr_grant;
  logic                w_any_req;
  logic                w_busy;
  logic                w_g_valid;
  logic                w_xfer;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (c_id_w)
  ) u_rr_arbiter (
    .req     (bus.req_valid_i),
    .last    (r_last),
    .grant   (w_rr_grant),
    .any_req (w_any_req)
  );

  assign w_busy    = (r_state == ARB_GRANT);
  assign w_g_valid = bus.req_valid_i[r_grant];
  assign w_xfer    = w_busy && w_g_valid && bus.ser_ready_i;

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_last_nxt     = r_last;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      ARB_IDLE: begin
        if (w_any_req) begin
          w_state_nxt    = ARB_GRANT;
          w_grant_nxt    = w_rr_grant;
          w_beat_cnt_nxt = '0;
        end
      end
      ARB_GRANT: begin
        if (w_xfer) begin
          w_beat_cnt_nxt = r_beat_cnt + 1'b1;
        end
        // A dropped valid ends the burst early so an idle owner cannot hold the link.
        if (!w_g_valid || (w_xfer && (r_beat_cnt == c_last_beat))) begin
          w_state_nxt = ARB_IDLE;
          w_last_nxt  = r_grant;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= ARB_IDLE;
      r_grant    <= '0;
      r_last     <= c_last_rst;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_last     <= w_last_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  // ser_valid_o depends only on state and the owner's valid, never on ser_ready_i.
  always_comb begin
    bus.ser_valid_o = 1'b0;
    bus.ser_data_o  = '0;
    bus.req_ready_o = '0;
    if (w_busy) begin
      bus.ser_valid_o          = w_g_valid;
      bus.ser_data_o           = bus.req_data_i[r_grant*DATA_WIDTH +: DATA_WIDTH];
      bus.req_ready_o[r_grant] = bus.ser_ready_i;
    end
  end

  assign bus.grant_id_o = r_grant;
  assign bus.busy_o     = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_serdes_tx_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_serdes_tx_arbiter
// Self-checking bench for serdes_tx_arbiter: directed scenarios plus random traffic.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_serdes_tx_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serdes_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

  serdes_tx_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]         q [NUM_REQ][$];
  logic [NUM_REQ-1:0] en = '1;
  logic [15:0]        o_t;
  logic [NUM_REQ-1:0] o_fire;

  // Observation tuple {busy, ser_valid, ser_data, req_ready, grant_id}.
  function automatic logic [15:0] mk(input logic b, input logic v, input logic [7:0] d,
                                     input logic [3:0] r, input logic [1:0] g);
    return {b, v, d, r, g};
  endfunction

  function automatic logic [15:0] cur();
    return {bus.busy_o, bus.ser_valid_o, bus.ser_data_o, bus.req_ready_o, bus.grant_id_o};
  endfunction

  task automatic drive_inputs();
    for (int k = 0; k < NUM_REQ; k++) begin
      bus.req_valid_i[k]         = en[k] && (q[k].size() > 0);
      bus.req_data_i[k*8 +: 8]   = (q[k].size() > 0) ? q[k][0] : 8'h00;
    end
  endtask

  // Sample outputs mid-cycle, then let producers pop accepted words after the edge.
  task automatic step();
    @(negedge clk);
    o_t    = cur();
    o_fire = bus.req_ready_o & bus.req_valid_i;
    @(posedge clk);
    #1;
    for (int k = 0; k < NUM_REQ; k++)
      if (o_fire[k] && q[k].size() > 0) void'(q[k].pop_front());
    drive_inputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) q[k].delete();
    en = '1;
    bus.ser_ready_i = 1'b1;
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] e;
    rst_n = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) q[k].delete();
    q[1].push_back(8'h11);
    q[3].push_back(8'h33);
    en = '1;
    bus.ser_ready_i = 1'b1;
    drive_inputs();
    #1;
    checks++;
    if (cur() !== 16'h0000) begin
      failures++;
      $display("FAIL reset_outputs: got %h required %h", cur(), 16'h0000);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      e = (c == 0) ? mk(1'b0, 1'b0, 8'h00, 4'b0000, 2'd0)
                   : mk(1'b1, 1'b1, 8'h11, 4'b0010, 2'd1);
      checks++;
      if (o_t !== e) begin
        failures++;
        $display("FAIL reset_first_grant cyc%0d: got %h required %h", c, o_t, e);
      end
    end
  endtask

  task automatic test_single();
    logic [15:0] e [9];
    do_reset();
    for (int i = 0; i < 6; i++) q[1].push_back(8'(8'hA0 + i));
    drive_inputs();
    e = '{mk(1'b0, 1'b0, 8'h00, 4'b0000, 2'd0), mk(1'b1, 1'b1, 8'hA0, 4'b0010, 2'd1),
          mk(1'b1, 1'b1, 8'hA1, 4'b0010, 2'd1), mk(1'b1, 1'b1, 8'hA2, 4'b0010, 2'd1),
          mk(1'b1, 1'b1, 8'hA3, 4'b0010, 2'd1), mk(1'b0, 1'b0, 8'h00, 4'b0000, 2'd1),
          mk(1'b1, 1'b1, 8'hA4, 4'b0010, 2'd1), mk(1'b1, 1'b1, 8'hA5, 4'b0010, 2'd1),
          mk(1'b1, 1'b0, 8'h00, 4'b0010, 2'd1)};
    for (int c = 0; c < 9; c++) begin
      step();
      checks++;
      if (o_t !== e[c]) begin
        failures++;
        $display("FAIL single cyc%0d: got %h required %h", c, o_t, e[c]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] e;
    int b, g;
    do_reset();
    for (int k = 0; k < NUM_REQ; k++)
      for (int i = 0; i < 8; i++) q[k].push_back(8'(k*16 + i));
    drive_inputs();
    for (int c = 0; c < 25; c++) begin
      step();
      b = c / 5;
      if (c % 5 == 0) begin
        e = mk(1'b0, 1'b0, 8'h00, 4'b0000, (c == 0) ? 2'd0 : 2'((b - 1) % 4));
      end else begin
        g = b % 4;
        e = mk(1'b1, 1'b1, 8'(g*16 + (b/4)*4 + (c%5 - 1)), 4'(1 << g), 2'(g));
      end
      checks++;
      if (o_t !== e) begin
        failures++;
        $display("FAIL round_robin cyc%0d: got %h required %h", c, o_t, e);
      end
    end
  endtask

  task automatic test_early_release();
    logic [15:0] e [12];
    do_reset();
    q[2].push_back(8'h20);
    q[2].push_back(8'h21);
    for (int i = 0; i < 6; i++) q[3].push_back(8'(8'h30 + i));
    drive_inputs();
    e = '{mk(1'b0, 1'b0, 8'h00, 4'b0000, 2'd0), mk(1'b1, 1'b1, 8'h20, 4'b0100, 2'd2),
          mk(1'b1, 1'b1, 8'h21, 4'b0100, 2'd2), mk(1'b1, 1'b0, 8'h00, 4'b0100, 2'd2),
          mk(1'b0, 1'b0, 8'h00, 4'b0000, 2'd2), mk(1'b1, 1'b1, 8'h30, 4'b1000, 2'd3),
          mk(1'b1, 1'b1, 8'h31, 4'b1000, 2'd3), mk(1'b1, 1'b1, 8'h32, 4'b1000, 2'd3),
          mk(1'b1, 1'b1, 8'h33, 4'b1000, 2'd3), mk(1'b0, 1'b0, 8'h00, 4'b0000, 2'd3),
          mk(1'b1, 1'b1, 8'h34, 4'b1000, 2'd3), mk(1'b1, 1'b1, 8'h35, 4'b1000, 2'd3)};
    for (int c = 0; c < 12; c++) begin
      step();
      checks++;
      if (o_t !== e[c]) begin
        failures++;
        $display("FAIL early_release cyc%0d: got %h required %h", c, o_t, e[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] e [13];
    do_reset();
    for (int i = 0; i < 6; i++) q[0].push_back(8'(8'h50 + i));
    drive_inputs();
    e[0]  = mk(1'b0, 1'b0, 8'h00, 4'b0000, 2'd0);
    e[1]  = mk(1'b1, 1'b1, 8'h50, 4'b0001, 2'd0);
    e[2]  = mk(1'b1, 1'b1, 8'h51, 4'b0001, 2'd0);
    for (int c = 3; c <= 7; c++) e[c] = mk(1'b1, 1'b1, 8'h52, 4'b0000, 2'd0);
    e[8]  = mk(1'b1, 1'b1, 8'h52, 4'b0001, 2'd0);
    e[9]  = mk(1'b1, 1'b1, 8'h53, 4'b0001, 2'd0);
    e[10] = mk(1'b0, 1'b0, 8'h00, 4'b0000, 2'd0);
    e[11] = mk(1'b1, 1'b1, 8'h54, 4'b0001, 2'd0);
    e[12] = mk(1'b1, 1'b1, 8'h55, 4'b0001, 2'd0);
    for (int c = 0; c < 13; c++) begin
      bus.ser_ready_i = !(c >= 3 && c <= 7);
      step();
      checks++;
      if (o_t !== e[c]) begin
        failures++;
        $display("FAIL backpressure cyc%0d: got %h required %h", c, o_t, e[c]);
      end
    end
    bus.ser_ready_i = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [15:0] e [5];
    logic [15:0] f [5];
    do_reset();
    q[1].push_back(8'h10);
    for (int i = 0; i < 8; i++) q[3].push_back(8'(8'h30 + i));
    drive_inputs();
    e = '{mk(1'b0, 1'b0, 8'h00, 4'b0000, 2'd0), mk(1'b1, 1'b1, 8'h10, 4'b0010, 2'd1),
          mk(1'b1, 1'b0, 8'h00, 4'b0010, 2'd1), mk(1'b0, 1'b0, 8'h00, 4'b0000, 2'd1),
          mk(1'b1, 1'b1, 8'h30, 4'b1000, 2'd3)};
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (o_t !== e[c]) begin
        failures++;
        $display("FAIL reset_mid_pre cyc%0d: got %h required %h", c, o_t, e[c]);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (cur() !== 16'h0000) begin
      failures++;
      $display("FAIL reset_mid_async: got %h required %h", cur(), 16'h0000);
    end
    @(posedge clk);
    #1;
    q[1].push_back(8'h11);
    drive_inputs();
    rst_n = 1'b1;
    f = '{mk(1'b0, 1'b0, 8'h00, 4'b0000, 2'd0), mk(1'b1, 1'b1, 8'h11, 4'b0010, 2'd1),
          mk(1'b1, 1'b0, 8'h00, 4'b0010, 2'd1), mk(1'b0, 1'b0, 8'h00, 4'b0000, 2'd1),
          mk(1'b1, 1'b1, 8'h31, 4'b1000, 2'd3)};
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (o_t !== f[c]) begin
        failures++;
        $display("FAIL reset_mid_post cyc%0d: got %h required %h", c, o_t, f[c]);
      end
    end
  endtask

  task automatic test_prio();
    logic [15:0] e [7];
    do_reset();
    for (int i = 0; i < 6; i++) q[0].push_back(8'(8'h60 + i));
    for (int i = 0; i < 8; i++) q[2].push_back(8'(8'h70 + i));
    drive_inputs();
    e[0] = mk(1'b0, 1'b0, 8'h00, 4'b0000, 2'd0);
    for (int c = 1; c <= 4; c++) e[c] = mk(1'b1, 1'b1, 8'(8'h60 + c - 1), 4'b0001, 2'd0);
    e[5] = mk(1'b0, 1'b0, 8'h00, 4'b0000, 2'd0);
`ifdef SERDES_ARB_PRIO0_EN
    e[6] = mk(1'b1, 1'b1, 8'h64, 4'b0001, 2'd0);
`else
    e[6] = mk(1'b1, 1'b1, 8'h70, 4'b0100, 2'd2);
`endif
    for (int c = 0; c < 7; c++) begin
      step();
      checks++;
      if (o_t !== e[c]) begin
        failures++;
        $display("FAIL prio cyc%0d: got %h required %h", c, o_t, e[c]);
      end
    end
  endtask

  // Reference model: tracks the current burst owner and beats sent, nothing more.
  task automatic test_random();
    bit          m_busy = 1'b0;
    int          m_g = 0, m_last = NUM_REQ - 1, m_beats = 0;
    logic [NUM_REQ-1:0] v;
    logic        r, took, found;
    logic [7:0]  d [NUM_REQ];
    logic [15:0] e;
    int          idx;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (q[k].size() < 3 && $urandom_range(0, 2) == 0) q[k].push_back(8'($urandom));
        en[k] = ($urandom_range(0, 4) != 0);
      end
      bus.ser_ready_i = ($urandom_range(0, 3) != 0);
      drive_inputs();
      v = bus.req_valid_i;
      r = bus.ser_ready_i;
      for (int k = 0; k < NUM_REQ; k++) d[k] = (q[k].size() > 0) ? q[k][0] : 8'h00;
      if (m_busy) e = mk(1'b1, v[m_g], d[m_g], r ? 4'(1 << m_g) : 4'b0000, 2'(m_g));
      else        e = mk(1'b0, 1'b0, 8'h00, 4'b0000, 2'(m_g));
      step();
      checks++;
      if (o_t !== e) begin
        failures++;
        $display("FAIL random cyc%0d: got %h required %h", c, o_t, e);
      end
      if (m_busy) begin
        took = v[m_g] && r;
        if (took) m_beats++;
        if (!v[m_g] || m_beats == MAX_BURST) begin
          m_busy = 1'b0;
          m_last = m_g;
        end
      end else if (v != '0) begin
        found = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
          idx = (m_last + off) % NUM_REQ;
          if (!found && v[idx]) begin
            m_g   = idx;
            found = 1'b1;
          end
        end
`ifdef SERDES_ARB_PRIO0_EN
        if (v[0]) m_g = 0;
`endif
        m_busy  = 1'b1;
        m_beats = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_backpressure();
    test_reset_mid();
    test_prio();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serdes_tx_arbiter.md
Name: serdes_tx_arbiter

Overview:
- Round-robin arbiter and burst scheduler that shares one serdes transmit input among NUM_REQ parallel requesters.
- Sits between requester producers and the serdes parallel_in_i / valid_in_i / ready_out_o handshake.
- Grants one requester at a time for a bounded burst of up to MAX_BURST beats and reports the granted source ID for framing and debug.

Parameters:
- NUM_REQ, 4, number of requesters; must be at least 2.
- DATA_WIDTH, 8, word width; must match the serdes DATA_WIDTH.
- MAX_BURST, 4, maximum accepted beats per grant; must be at least 1.

Ports:
- clk_i  input  1  single clock.
- rst_n_i  input  1  asynchronous active-low reset.
- req_data_i  input  NUM_REQ*DATA_WIDTH  requester words; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_valid_i  input  NUM_REQ  per-requester valid.
- req_ready_o  output  NUM_REQ  per-requester ready; at most one bit high.
- ser_data_o  output  DATA_WIDTH  to serdes parallel_in_i.
- ser_valid_o  output  1  to serdes valid_in_i.
- ser_ready_i  input  1  from serdes ready_out_o.
- grant_id_o  output  $clog2(NUM_REQ)  index of the currently granted requester.
- busy_o  output  1  high while in GRANT.

Behaviour:
- Clock and reset: one clock (clk_i); reset rst_n_i is asynchronous, active-low.
- Reset values:
  - ser_valid_o=0, req_ready_o=0, ser_data_o=0, grant_id_o=0, busy_o=0.
  - State=IDLE, beat counter=0.
  - Last-grant pointer=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE and GRANT.
- IDLE:
  - Search req_valid_i starting at (last+1) mod NUM_REQ, wrapping.
  - If any bit is set: register grant_id_o, clear the beat counter, go to GRANT on the next edge.
  - Arbitration latency is 1 cycle, and every grant costs a minimum 1-cycle IDLE bubble.
  - Outputs in IDLE: ser_valid_o=0, req_ready_o=0.
- GRANT, with g = grant_id_o:
  - ser_data_o = req_data_i[g], combinational mux.
  - ser_valid_o = req_valid_i[g].
  - req_ready_o[g] = ser_ready_i; all other ready bits are 0.
  - A beat transfers when req_valid_i[g] and ser_ready_i are both high; the beat counter increments on each transfer.
- Release to IDLE, setting last=g, occurs when either condition holds:
  - a transfer occurs while the counter equals MAX_BURST-1, or
  - req_valid_i[g] is low in any GRANT cycle.
- Backpressure: ser_ready_i low holds GRANT indefinitely. No timeout; no beat is lost or duplicated.
- Fairness: a requester re-asserting immediately after release waits for all other active requesters before it is served again.
- Only one valid requester: it is re-granted after each 1-cycle bubble.
- busy_o = (state==GRANT).
- No combinational path from ser_ready_i to ser_valid_o.
- Reset mid-burst: state returns to IDLE immediately and the pointer is reset. The interrupted beat counts as not transferred.

Optional Feature:
- Macro: SERDES_ARB_PRIO0_EN.
- Defined: in IDLE, requester 0 wins whenever req_valid_i[0]=1, regardless of the pointer. The pointer still updates on release, and other requesters are served round-robin when requester 0 is idle. Burst limit is unchanged, so requester 0 can starve others by design.
- Undefined: pure round-robin as described in Behaviour.

Decomposition:
- Package serdes_arb_pkg:
  - state enum arb_state_e {ARB_IDLE, ARB_GRANT}.
  - function rr_next(req, last) returning the first set index after last with wrap-around.
- Sub-module rr_arbiter (combinational round-robin pick: inputs req and last, outputs grant index and any_req). It is instantiated once and is unit-testable on its own.

Test Plan:
- Single requester: only req 1 valid, 6 words 0xA0..0xA5, ser_ready_i=1.
  - Expect grant_id_o=1.
  - Beats 0xA0..0xA3, then 1 IDLE cycle, then 0xA4..0xA5.
  - req_ready_o=4'b0010 only during GRANT.
- Round-robin: all 4 requesters valid continuously, MAX_BURST=4.
  - Grant order 0,1,2,3,0.
  - Each burst is exactly 4 beats separated by one bubble.
- Early release: req 2 drops valid after 2 beats.
  - Expect release after a 2-beat burst and the next grant to req 3.
  - Counter is cleared at the new grant.
- Backpressure: ser_ready_i low for 5 cycles mid-burst.
  - ser_valid_o stays high and ser_data_o is stable.
  - No req_ready_o is asserted, and the burst resumes with the same beat count.
- Reset mid-burst: assert rst_n_i low during beat 2 of req 3.
  - All outputs go to 0 asynchronously.
  - After release, the first grant goes to the lowest valid index starting at 0.
- SERDES_ARB_PRIO0_EN: reqs 0 and 2 both valid, last=0.
  - With the macro defined, req 0 is granted again.
  - Without it, req 2 is granted.
